// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake and decoded-field bundle for decode_stage.
//   in_valid/in_ready/instruction : fetch side (valid/ready, instruction word)
//   out_valid/out_ready           : execute side handshake
//   op, rd, rs, func, imm, offs,
//   rt, imm_ext, illegal          : decoded fields of the entry at the output
// Modports:
//   slave  : the decode stage itself
//   master : the environment (fetch + execute) around the stage
interface decode_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned FUNC_W  = 4,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned XLEN    = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_W-1:0]       instruction;
  logic                     out_valid;
  logic                     out_ready;
  logic [OP_W-1:0]          op;
  logic [REG_W-1:0]         rd;
  logic [REG_W-1:0]         rs;
  logic [FUNC_W-1:0]        func;
  logic [IMM_W-1:0]         imm;
  logic [FUNC_W+IMM_W-1:0]  offs;
  logic [REG_W-1:0]         rt;
  logic [XLEN-1:0]          imm_ext;
  logic                     illegal;

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, op, rd, rs, func, imm, offs, rt, imm_ext, illegal
  );

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, op, rd, rs, func, imm, offs, rt, imm_ext, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: handshaked instruction decode stage between fetch and execute.
// Splits the instruction word into op/rd/rs/func/imm/offs/rt, extends the
// immediate (sign or zero per opcode) and flags illegal opcodes. A main entry
// register drives the outputs; a skid entry absorbs one extra word so that
// in_ready comes straight from a flop.
// Ports:
//   clk          : clock, rising edge
//   rst_async    : asynchronous active-high reset
//   flush        : synchronous kill of both buffered entries
//   bus          : decode_stage_if.slave (input/output handshakes, fields)
//   decode_count : number of output handshakes since reset (wraps)
module decode_stage #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned FUNC_W  = 4,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned XLEN    = 32,
  parameter logic [2**OP_W-1:0] LEGAL_OP_MASK = '1,
  parameter logic [2**OP_W-1:0] SEXT_OP_MASK  = '0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] decode_count
);

  if (OP_W + 2*REG_W + FUNC_W + IMM_W != INSTR_W) begin : g_bad_fields
    $error("decode_stage: field widths do not add up to INSTR_W");
  end
  if (XLEN < IMM_W) begin : g_bad_xlen
    $error("decode_stage: XLEN must be at least IMM_W");
  end
  if (REG_W > IMM_W) begin : g_bad_reg
    $error("decode_stage: REG_W must not exceed IMM_W");
  end

  typedef struct packed {
    logic [OP_W-1:0]         op;
    logic [REG_W-1:0]        rd;
    logic [REG_W-1:0]        rs;
    logic [FUNC_W-1:0]       func;
    logic [IMM_W-1:0]        imm;
    logic [FUNC_W+IMM_W-1:0] offs;
    logic [REG_W-1:0]        rt;
    logic [XLEN-1:0]         imm_ext;
    logic                    illegal;
  } entry_t;

  entry_t           dec;
  entry_t           main_q;
  entry_t           skid_q;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q;

  // Field decode of the incoming word; registered into whichever entry loads.
  always_comb begin
    dec         = '0;
    dec.op      = bus.instruction[INSTR_W-1 -: OP_W];
    dec.rd      = bus.instruction[INSTR_W-OP_W-1 -: REG_W];
    dec.rs      = bus.instruction[INSTR_W-OP_W-REG_W-1 -: REG_W];
    dec.func    = bus.instruction[FUNC_W+IMM_W-1 -: FUNC_W];
    dec.imm     = bus.instruction[IMM_W-1:0];
    dec.offs    = bus.instruction[FUNC_W+IMM_W-1:0];
    dec.rt      = bus.instruction[REG_W-1:0];
    dec.imm_ext = SEXT_OP_MASK[dec.op] ? XLEN'($signed(dec.imm)) : XLEN'(dec.imm);
    dec.illegal = ~LEGAL_OP_MASK[dec.op];
  end

  assign accept   = bus.in_valid & ~skid_valid;
  assign out_xfer = main_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      count_q    <= '0;
    end else begin
      // Counted even in a flush cycle: the output handshake already happened.
      if (out_xfer) begin
        count_q <= count_q + 1'b1;
      end

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || out_xfer) begin
        // Skid holds the older word, so it refills main first. When skid is
        // full in_ready is low, so no input can arrive in the same cycle.
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.op        = main_q.op;
  assign bus.rd        = main_q.rd;
  assign bus.rs        = main_q.rs;
  assign bus.func      = main_q.func;
  assign bus.imm       = main_q.imm;
  assign bus.offs      = main_q.offs;
  assign bus.rt        = main_q.rt;
  assign bus.imm_ext   = main_q.imm_ext;
  assign bus.illegal   = main_q.illegal;
  assign decode_count  = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: bench for decode_stage. Instance A is the 32-bit layout
// with opcode 0xF illegal and opcode 0xA sign-extending; instance B is a
// 24-bit layout (IMM_W=8) with the same opcode rules. The reference model is
// an in-order queue of at most two accepted words plus a field extractor
// written with shifts and modulo arithmetic.
module tb_decode_stage;
  localparam logic [15:0] LEGAL = 16'h7FFF;
  localparam logic [15:0] SEXT  = 16'h0400;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        flush_a;
  logic        flush_b;
  logic [31:0] count_a;
  logic [31:0] count_b;

  always #5 clk = ~clk;

  decode_stage_if #(.INSTR_W(32), .IMM_W(16)) ba ();
  decode_stage_if #(.INSTR_W(24), .IMM_W(8))  bb ();

  decode_stage #(
    .INSTR_W(32), .IMM_W(16), .LEGAL_OP_MASK(LEGAL), .SEXT_OP_MASK(SEXT)
  ) dut_a (
    .clk(clk), .rst_async(rst_async), .flush(flush_a), .bus(ba.slave), .decode_count(count_a)
  );

  decode_stage #(
    .INSTR_W(24), .IMM_W(8), .LEGAL_OP_MASK(LEGAL), .SEXT_OP_MASK(SEXT)
  ) dut_b (
    .clk(clk), .rst_async(rst_async), .flush(flush_b), .bus(bb.slave), .decode_count(count_b)
  );

  typedef struct {
    logic [31:0] op, rd, rs, func, imm, offs, rt, ext;
    logic        ill;
  } ref_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] cnt_m = '0;

  // Field layout: op is the top nibble, then rd, rs, func; imm is the low
  // immw bits. Opcode 15 is illegal, opcode 10 sign-extends.
  function automatic ref_t model(input logic [31:0] w, input int iw, input int immw);
    ref_t r;
    r.op   = (w >> (iw - 4)) % 16;
    r.rd   = (w >> (iw - 8)) % 16;
    r.rs   = (w >> (iw - 12)) % 16;
    r.func = (w >> immw) % 16;
    r.imm  = w % (32'd1 << immw);
    r.offs = w % (32'd1 << (immw + 4));
    r.rt   = w % 16;
    r.ill  = (r.op == 15);
    if (r.op == 10 && r.imm >= (32'd1 << (immw - 1))) r.ext = r.imm - (32'd1 << immw);
    else r.ext = r.imm;
    return r;
  endfunction

  // Drives one cycle on instance A and advances the reference queue.
  task automatic cycle_a(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    logic acc, ox;
    ba.in_valid    = v;
    ba.instruction = w;
    ba.out_ready   = rdy;
    flush_a        = fl;
    acc = v && (q.size() < 2);
    ox  = rdy && (q.size() > 0);
    @(posedge clk); #1;
    if (ox) cnt_m = cnt_m + 1;
    if (fl) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    ba.in_valid = 1'b0;
    flush_a     = 1'b0;
  endtask

  task automatic test_reset();
    logic [256:0] f;
    rst_async = 1'b1;
    ba.in_valid = 0; ba.instruction = '0; ba.out_ready = 0; flush_a = 0;
    bb.in_valid = 0; bb.instruction = '0; bb.out_ready = 1; flush_b = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ba.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ba.out_valid); end
    n_cmp++; if (ba.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", ba.in_ready); end
    n_cmp++; if (count_a !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_a); end
    f = {32'(ba.op), 32'(ba.rd), 32'(ba.rs), 32'(ba.func), 32'(ba.imm), 32'(ba.offs), 32'(ba.rt), ba.imm_ext, ba.illegal};
    n_cmp++; if (f !== '0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", f); end
    n_cmp++; if (bb.out_valid !== 1'b0 || bb.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_hs: got v=%b r=%b want v=0 r=1", bb.out_valid, bb.in_ready); end
    @(negedge clk) rst_async = 1'b0;
    @(posedge clk); #1;
    q.delete(); cnt_m = '0;
  endtask

  task automatic test_streaming();
    cycle_a(1, 32'h1234_5678, 1, 0);
    n_cmp++; if (ba.out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid0: got %b want 1", ba.out_valid); end
    n_cmp++;
    if ({ba.op, ba.rd, ba.rs, ba.func, ba.imm, ba.offs, ba.rt} !== {4'h1, 4'h2, 4'h3, 4'h4, 16'h5678, 20'h45678, 4'h8}) begin
      n_bad++; $display("FAIL stream_fields0: got %h want 1234567845678 8", {ba.op, ba.rd, ba.rs, ba.func, ba.imm, ba.offs, ba.rt});
    end
    cycle_a(1, 32'hA0F1_8001, 1, 0);
    n_cmp++; if (ba.op !== 4'hA) begin n_bad++; $display("FAIL stream_op1: got %h want a", ba.op); end
    n_cmp++; if (ba.in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready: got %b want 1", ba.in_ready); end
    cycle_a(0, '0, 1, 0);
    n_cmp++; if (count_a !== 32'd2) begin n_bad++; $display("FAIL stream_count: got %0d want 2", count_a); end
    n_cmp++; if (ba.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drained: got %b want 0", ba.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    base = cnt_m;
    cycle_a(1, 32'h2111_0001, 0, 0);
    n_cmp++; if (ba.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1: got %b want 1", ba.in_ready); end
    cycle_a(1, 32'h3222_0002, 0, 0);
    n_cmp++; if (ba.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready2: got %b want 0", ba.in_ready); end
    cycle_a(1, 32'h4333_0003, 0, 0);
    n_cmp++; if ({ba.out_valid, ba.in_ready, ba.op, ba.imm} !== {1'b1, 1'b0, 4'h2, 16'h0001}) begin
      n_bad++; $display("FAIL bp_stall: got %h want 2 0 2 0001", {ba.out_valid, ba.in_ready, ba.op, ba.imm});
    end
    cycle_a(1, 32'h4333_0003, 1, 0);
    n_cmp++; if ({ba.op, ba.imm, ba.in_ready} !== {4'h3, 16'h0002, 1'b1}) begin
      n_bad++; $display("FAIL bp_second: got %h want 3 0002 1", {ba.op, ba.imm, ba.in_ready});
    end
    cycle_a(1, 32'h4333_0003, 1, 0);
    n_cmp++; if ({ba.out_valid, ba.op, ba.imm} !== {1'b1, 4'h4, 16'h0003}) begin
      n_bad++; $display("FAIL bp_third: got %h want 1 4 0003", {ba.out_valid, ba.op, ba.imm});
    end
    cycle_a(0, '0, 1, 0);
    n_cmp++; if (count_a !== base + 32'd3) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", count_a, base + 3); end
  endtask

  task automatic test_extension();
    cycle_a(1, 32'hA000_8001, 1, 0);
    n_cmp++; if (ba.imm_ext !== 32'hFFFF_8001) begin n_bad++; $display("FAIL ext_sign: got %h want ffff8001", ba.imm_ext); end
    cycle_a(1, 32'h1000_8001, 1, 0);
    n_cmp++; if (ba.imm_ext !== 32'h0000_8001) begin n_bad++; $display("FAIL ext_zero: got %h want 00008001", ba.imm_ext); end
    cycle_a(0, '0, 1, 0);
  endtask

  task automatic test_illegal();
    cycle_a(1, 32'h1234_5678, 1, 0);
    n_cmp++; if ({ba.out_valid, ba.illegal} !== 2'b10) begin n_bad++; $display("FAIL ill_before: got %b want 10", {ba.out_valid, ba.illegal}); end
    cycle_a(1, 32'hF000_0000, 1, 0);
    n_cmp++; if ({ba.out_valid, ba.illegal, ba.op} !== {2'b11, 4'hF}) begin n_bad++; $display("FAIL ill_flag: got %h want 3f", {ba.out_valid, ba.illegal, ba.op}); end
    cycle_a(1, 32'h3000_0010, 1, 0);
    n_cmp++; if ({ba.out_valid, ba.illegal, ba.op, ba.imm} !== {2'b10, 4'h3, 16'h0010}) begin
      n_bad++; $display("FAIL ill_after: got %h want 2 3 0010", {ba.out_valid, ba.illegal, ba.op, ba.imm});
    end
    cycle_a(0, '0, 1, 0);
  endtask

  task automatic test_flush();
    logic [31:0] base;
    cycle_a(1, 32'h5000_0001, 0, 0);
    cycle_a(1, 32'h6000_0002, 0, 0);
    base = count_a;
    cycle_a(1, 32'h7000_0003, 0, 1);
    n_cmp++; if ({ba.out_valid, ba.in_ready} !== 2'b01) begin n_bad++; $display("FAIL flush_hs: got %b want 01", {ba.out_valid, ba.in_ready}); end
    n_cmp++; if (count_a !== base) begin n_bad++; $display("FAIL flush_count: got %0d want %0d", count_a, base); end
    cycle_a(0, '0, 1, 0);
    n_cmp++; if (ba.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_nothing: got %b want 0", ba.out_valid); end
    n_cmp++; if (count_a !== cnt_m) begin n_bad++; $display("FAIL flush_count2: got %0d want %0d", count_a, cnt_m); end
  endtask

  task automatic test_random();
    ref_t m;
    logic [256:0] got, exp;
    logic [31:0] w;
    for (int i = 0; i < 500; i++) begin
      n_cmp++; if (ba.out_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, ba.out_valid, q.size() > 0); end
      n_cmp++; if (ba.in_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, ba.in_ready, q.size() < 2); end
      n_cmp++; if (count_a !== cnt_m) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count_a, cnt_m); end
      if (q.size() > 0) begin
        m   = model(q[0], 32, 16);
        got = {32'(ba.op), 32'(ba.rd), 32'(ba.rs), 32'(ba.func), 32'(ba.imm), 32'(ba.offs), 32'(ba.rt), ba.imm_ext, ba.illegal};
        exp = {m.op, m.rd, m.rs, m.func, m.imm, m.offs, m.rt, m.ext, m.ill};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rnd_fields[%0d]: got %h want %h", i, got, exp); end
      end
      w = $urandom;
      case ($urandom_range(0, 7))
        0: w[31:28] = 4'hF;
        1, 2: w[31:28] = 4'hA;
        default: ;
      endcase
      cycle_a($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    cycle_a(0, '0, 1, 0);
    cycle_a(0, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    logic [256:0] f;
    cycle_a(1, 32'h8123_4567, 0, 0);
    cycle_a(1, 32'h9765_4321, 0, 0);
    #3 rst_async = 1'b1;
    #1;
    n_cmp++; if ({ba.out_valid, ba.in_ready} !== 2'b01) begin n_bad++; $display("FAIL rmid_hs: got %b want 01", {ba.out_valid, ba.in_ready}); end
    n_cmp++; if (count_a !== 32'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", count_a); end
    f = {32'(ba.op), 32'(ba.rd), 32'(ba.rs), 32'(ba.func), 32'(ba.imm), 32'(ba.offs), 32'(ba.rt), ba.imm_ext, ba.illegal};
    n_cmp++; if (f !== '0) begin n_bad++; $display("FAIL rmid_fields: got %h want 0", f); end
    q.delete(); cnt_m = '0;
    @(negedge clk) rst_async = 1'b0;
    @(posedge clk); #1;
    cycle_a(1, 32'h1234_5678, 1, 0);
    n_cmp++; if ({ba.out_valid, ba.op, ba.imm} !== {1'b1, 4'h1, 16'h5678}) begin
      n_bad++; $display("FAIL rmid_resume: got %h want 1 1 5678", {ba.out_valid, ba.op, ba.imm});
    end
    cycle_a(0, '0, 1, 0);
  endtask

  task automatic test_narrow();
    ref_t m;
    logic [23:0] w;
    logic [31:0] nout;
    logic [256:0] got, exp;
    nout = count_b;
    bb.out_ready = 1'b1;
    bb.in_valid = 1'b1; bb.instruction = 24'hA23F81;
    @(posedge clk); #1;
    n_cmp++;
    if ({bb.op, bb.rd, bb.rs, bb.func, bb.imm, bb.offs, bb.rt, bb.imm_ext} !== {4'hA, 4'h2, 4'h3, 4'hF, 8'h81, 12'hF81, 4'h1, 32'hFFFF_FF81}) begin
      n_bad++; $display("FAIL narrow_fields: got %h want a23f81f811ffffff81", {bb.op, bb.rd, bb.rs, bb.func, bb.imm, bb.offs, bb.rt, bb.imm_ext});
    end
    for (int i = 0; i < 20; i++) begin
      w = 24'($urandom);
      bb.instruction = w;
      @(posedge clk); #1;
      nout = nout + 1;
      m   = model({8'h00, w}, 24, 8);
      got = {32'(bb.op), 32'(bb.rd), 32'(bb.rs), 32'(bb.func), 32'(bb.imm), 32'(bb.offs), 32'(bb.rt), bb.imm_ext, bb.illegal};
      exp = {m.op, m.rd, m.rs, m.func, m.imm, m.offs, m.rt, m.ext, m.ill};
      n_cmp++; if (bb.out_valid !== 1'b1 || got !== exp) begin n_bad++; $display("FAIL narrow_rnd[%0d]: got v=%b %h want %h", i, bb.out_valid, got, exp); end
    end
    bb.in_valid = 1'b0;
    @(posedge clk); #1;
    nout = nout + 1;
    n_cmp++; if (count_b !== nout) begin n_bad++; $display("FAIL narrow_count: got %0d want %0d", count_b, nout); end
    n_cmp++; if (bb.out_valid !== 1'b0) begin n_bad++; $display("FAIL narrow_drained: got %b want 0", bb.out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_extension();
    test_illegal();
    test_flush();
    test_random();
    test_reset_mid();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
